// File: rtl/iic_slv_ctrl.sv
// iic_slv_ctrl: IIC responder bridging bus transfers to a simple register port.
// SCL/SDA are synchronized; START/STOP and bit edges are decoded on clk.
module iic_slv_ctrl #(
  parameter logic [6:0] SLV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       oe_q, oe_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic       ld_q, ld_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;

  // [0],[1] form the synchronizer; [2] holds the previous synced value
  logic scl_s, sda_s, scl_p, sda_p;
  assign scl_s = scl_q[1];
  assign sda_s = sda_q[1];
  assign scl_p = scl_q[2];
  assign sda_p = sda_q[2];

  logic scl_rise, scl_fall, start, stop, last;
  logic [7:0] byte_in;
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start    = scl_s & scl_p & sda_p & ~sda_s;
  assign stop     = scl_s & scl_p & ~sda_p & sda_s;
  assign last     = scl_rise && (cnt_q == 4'd7);
  assign byte_in  = {sh_q, sda_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      cnt_q   <= 4'd0;
      sh_q    <= 7'd0;
      tx_q    <= 8'd0;
      ptr_q   <= 8'd0;
      wdata_q <= 8'd0;
      oe_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ld_q    <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      scl_q   <= {scl_q[1:0], scl_in};
      sda_q   <= {sda_q[1:0], sda_in};
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      ptr_q   <= ptr_d;
      wdata_q <= wdata_d;
      oe_q    <= oe_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    ptr_d   = ptr_q;
    wdata_d = wdata_q;
    oe_d    = oe_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ld_d    = rd_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    if (wr_q) ptr_d = ptr_q + 8'd1;
    // read data arrives one clk after the reg_rd strobe
    if (ld_q) tx_d = reg_rdata;
    if (start) begin
      state_d = DEV_ADDR;
      cnt_d   = 4'd0;
      sh_d    = 7'd0;
      oe_d    = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      sh_d    = 7'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        DEV_ADDR: begin
          if (scl_rise) begin
            sh_d  = byte_in[6:0];
            cnt_d = cnt_q + 4'd1;
          end
          if (last) begin
            cnt_d = 4'd0;
            if (byte_in[7:1] == SLV_ADDR) begin
              state_d = DEV_ACK;
              busy_d  = 1'b1;
              rw_d    = byte_in[0];
              rd_d    = byte_in[0];
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        REG_ADDR: begin
          if (scl_rise) begin
            sh_d  = byte_in[6:0];
            cnt_d = cnt_q + 4'd1;
          end
          if (last) begin
            cnt_d   = 4'd0;
            ptr_d   = byte_in;
            state_d = REG_ACK;
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            sh_d  = byte_in[6:0];
            cnt_d = cnt_q + 4'd1;
          end
          if (last) begin
            cnt_d   = 4'd0;
            wr_d    = 1'b1;
            wdata_d = byte_in;
            state_d = WR_ACK;
          end
        end
        DEV_ACK, REG_ACK, WR_ACK: begin
          // cnt=0: ACK not yet driven; cnt=1: ACK driven, release next fall
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              oe_d  = 1'b1;
              cnt_d = 4'd1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = 4'd0;
              if (state_q == DEV_ACK && rw_q) begin
                state_d = RD_DATA;
                oe_d    = ~tx_q[7];
              end else if (state_q == DEV_ACK) begin
                state_d = REG_ADDR;
              end else begin
                state_d = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              oe_d = ~tx_q[7];
            end else if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = RD_ACK;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
              oe_d = ~tx_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            cnt_d = 4'd0;
            if (!sda_s) begin
              ptr_d   = ptr_q + 8'd1;
              rd_d    = 1'b1;
              state_d = RD_DATA;
            end else begin
              busy_d  = 1'b0;
              state_d = WAIT_STOP;
            end
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_oe    = oe_q;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign reg_rd    = rd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_iic_slv_ctrl.sv
// tb_iic_slv_ctrl: bit-banged IIC master against iic_slv_ctrl.
// Write vectors come from a table; read/abort/reset cases are hand sequences.
module tb_iic_slv_ctrl;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       scl_in, sda_in, sda_oe;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_wr, reg_rd, busy;

  int errs = 0;
  int checks = 0;

  logic [7:0]  mem [256];
  logic [15:0] wrq[$];
  logic [7:0]  rdq[$];
  logic        oe_seen;
  logic        ack;
  logic [7:0]  b;

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] nxt;
  } wvec_t;
  wvec_t tbl [3];

  always #5 clk = ~clk;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  iic_slv_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr   (reg_wr),
    .reg_rd   (reg_rd),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  always @(posedge clk) if (reg_rd) reg_rdata <= mem[reg_addr];

  always @(negedge clk) begin
    if (reg_wr) wrq.push_back({reg_addr, reg_wdata});
    if (reg_rd) rdq.push_back(reg_addr);
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  task automatic put_bit(input logic v);
    sda_m = v;    wq(Q);
    scl_m = 1'b1; wq(2 * Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic a);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    #1 a = ~sda_in;
    wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic get_byte(input logic mack, output logic [7:0] d);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq(Q);
      scl_m = 1'b1; wq(Q);
      #1 d[i] = sda_in;
      wq(Q);
      scl_m = 1'b0;
    end
    wq(Q);
    put_bit(~mack);
    sda_m = 1'b1;
  endtask

  initial begin
    tbl[0] = '{8'h10, 8'h5A, 8'hC3, 8'h10, 8'h11, 8'h12};
    tbl[1] = '{8'hFF, 8'h11, 8'h22, 8'hFF, 8'h00, 8'h01};
    tbl[2] = '{8'h7F, 8'h00, 8'hFF, 8'h7F, 8'h80, 8'h81};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'h7E;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; oe_seen = 1'b0;
    wq(3);
    #1;
    chk("rst sda_oe", sda_oe, 1'b0);
    chk("rst reg_wr", reg_wr, 1'b0);
    chk("rst reg_rd", reg_rd, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst reg_addr", reg_addr, 8'h00);
    chk("rst reg_wdata", reg_wdata, 8'h00);
    rst = 1'b0;
    wq(5);

    for (int v = 0; v < 3; v++) begin
      wrq.delete();
      i2c_start;
      put_byte(8'hA0, ack);
      chk("wr dev ack", ack, 1'b1);
      chk("wr busy", busy, 1'b1);
      put_byte(tbl[v].ptr, ack);
      chk("wr reg ack", ack, 1'b1);
      put_byte(tbl[v].d0, ack);
      chk("wr d0 ack", ack, 1'b1);
      put_byte(tbl[v].d1, ack);
      chk("wr d1 ack", ack, 1'b1);
      i2c_stop;
      wq(8);
      chk("wr count", 16'(wrq.size()), 16'd2);
      if (wrq.size() == 2) begin
        chk("wr0", wrq[0], {tbl[v].a0, tbl[v].d0});
        chk("wr1", wrq[1], {tbl[v].a1, tbl[v].d1});
      end
      chk("wr busy end", busy, 1'b0);
      chk("wr ptr end", reg_addr, tbl[v].nxt);
    end

    // read with repeated START, master ACK then NACK
    wrq.delete(); rdq.delete();
    i2c_start;
    put_byte(8'hA0, ack);
    chk("rd dev ack", ack, 1'b1);
    put_byte(8'h20, ack);
    chk("rd reg ack", ack, 1'b1);
    i2c_start;
    put_byte(8'hA1, ack);
    chk("rd dev2 ack", ack, 1'b1);
    get_byte(1'b1, b);
    chk("rd byte0", b, 8'h3C);
    get_byte(1'b0, b);
    chk("rd byte1", b, 8'h7E);
    wq(4);
    chk("rd busy nack", busy, 1'b0);
    i2c_stop;
    wq(8);
    chk("rd count", 16'(rdq.size()), 16'd2);
    if (rdq.size() == 2) begin
      chk("rd addr0", rdq[0], 8'h20);
      chk("rd addr1", rdq[1], 8'h21);
    end
    chk("rd no wr", 16'(wrq.size()), 16'd0);

    // address mismatch
    wrq.delete(); rdq.delete();
    i2c_start;
    oe_seen = 1'b0;
    put_byte(8'h42, ack);
    chk("mm dev ack", ack, 1'b0);
    put_byte(8'h55, ack);
    chk("mm data ack", ack, 1'b0);
    chk("mm busy", busy, 1'b0);
    i2c_stop;
    wq(8);
    chk("mm oe seen", oe_seen, 1'b0);
    chk("mm no wr", 16'(wrq.size()), 16'd0);
    chk("mm no rd", 16'(rdq.size()), 16'd0);

    // STOP after four data bits
    wrq.delete();
    i2c_start;
    put_byte(8'hA0, ack);
    put_byte(8'h30, ack);
    chk("ab reg ack", ack, 1'b1);
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    i2c_stop;
    wq(8);
    chk("ab no wr", 16'(wrq.size()), 16'd0);
    chk("ab busy", busy, 1'b0);
    chk("ab ptr kept", reg_addr, 8'h30);
    put_byte(8'hA0, ack);
    chk("ab idle ignores", ack, 1'b0);
    i2c_stop;
    wq(8);

    // reset while driving a read bit (mem[0x30] = 0x00 -> SDA held low)
    i2c_start;
    put_byte(8'hA0, ack);
    put_byte(8'h30, ack);
    i2c_start;
    put_byte(8'hA1, ack);
    chk("rr dev ack", ack, 1'b1);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    #1 chk("rr oe before", sda_oe, 1'b1);
    rst = 1'b1;
    #1;
    chk("rr oe at rst", sda_oe, 1'b0);
    chk("rr busy at rst", busy, 1'b0);
    chk("rr ptr at rst", reg_addr, 8'h00);
    wq(2);
    rst = 1'b0;
    oe_seen = 1'b0;
    wq(Q);
    scl_m = 1'b0; wq(Q);
    for (int i = 0; i < 7; i++) put_bit(1'b1);
    put_bit(1'b1);
    put_byte(8'hA0, ack);
    chk("rr ignores bus", ack, 1'b0);
    i2c_stop;
    wq(8);
    chk("rr oe after", oe_seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/iic_slv_ctrl.md
IIC_SLV_CTRL -- requirements
Module: iic_slv_ctrl

Interface
REQ-001 SHALL have parameter SLV_ADDR, default 7'h50, 7-bit device address this responder answers to.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge; fclk >= 16x SCL frequency.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port scl_in  input  1  raw IIC SCL line, asynchronous to clk.
REQ-005 SHALL have port sda_in  input  1  raw IIC SDA line, asynchronous to clk.
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-007 SHALL have port reg_addr  output  8  register pointer for current access.
REQ-008 SHALL have port reg_wdata  output  8  write data, valid while reg_wr=1.
REQ-009 SHALL have port reg_wr  output  1  one-clk write strobe.
REQ-010 SHALL have port reg_rd  output  1  one-clk read request at reg_addr.
REQ-011 SHALL have port reg_rdata  input  8  read data, sampled exactly one clk after reg_rd.
REQ-012 SHALL have port busy  output  1  high from address-matched START until STOP or NACK exit.

Function
REQ-013 SHALL pass scl_in and sda_in through 2-flop synchronizers; edge/condition detection on synchronized values (3-clk input latency).
REQ-014 SHALL detect START as synced SDA falling while synced SCL high; STOP as synced SDA rising while SCL high.
REQ-015 SHALL sample SDA bits on synced SCL rising edge, MSB first; SHALL change sda_oe only on synced SCL falling edge.
REQ-016 SHALL implement states IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-017 IDLE: START -> DEV_ADDR with bit counter cleared; all other SDA/SCL activity ignored.
REQ-018 DEV_ADDR: after 8th bit, byte[7:1]==SLV_ADDR -> DEV_ACK, busy=1; mismatch -> WAIT_STOP, sda_oe never asserted.
REQ-019 DEV_ACK: sda_oe=1 from next SCL fall to following SCL fall; then R/W=0 -> REG_ADDR, R/W=1 -> RD_DATA.
REQ-020 REG_ADDR: 8th bit loads reg_addr; REG_ACK drives ACK as REQ-019, then -> WR_DATA.
REQ-021 WR_DATA: on 8th bit, reg_wr=1 for one clk with reg_wdata=byte, reg_addr=pointer; pointer increments the next clk; WR_ACK drives ACK, then -> WR_DATA.
REQ-022 Read: reg_rd pulses on the clk the R/W=1 bit is accepted; reg_rdata loaded into shift register next clk; bit7 driven (sda_oe = ~bit) at the ACK-ending SCL fall.
REQ-023 RD_DATA: shift one bit per SCL fall; after 8th bit, sda_oe=0 at that bit's closing SCL fall -> RD_ACK.
REQ-024 RD_ACK: master ACK (SDA=0 at SCL rise) -> pointer+1, reg_rd pulse, -> RD_DATA; NACK -> WAIT_STOP, busy=0.
REQ-025 Pointer arithmetic SHALL be 8-bit modulo: 8'hFF + 1 = 8'h00.
REQ-026 Repeated START in any state SHALL go to DEV_ADDR, keep pointer, release sda_oe.
REQ-027 STOP in any state SHALL go to IDLE, sda_oe=0, busy=0; partial byte discarded, no reg_wr.
REQ-028 START and bit sampling SHALL never coincide; a START/STOP condition takes priority over any data bit on that clk.
REQ-029 Pointer retained across transactions; only REG_ADDR byte or reset changes it besides increments.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, sda_oe=0, reg_wr=0, reg_rd=0, busy=0, reg_addr=8'h00, reg_wdata=8'h00, shift register and bit counter 0, synchronizers to 1.
REQ-031 rst asserted mid-transfer SHALL release SDA at once; after release the block ignores the bus until next START.

Verification
REQ-032 Write: START, 0xA0, 0x10, 0x5A, 0xC3, STOP -> ACK on all 4 bytes; reg_wr at addr 0x10 data 0x5A, then 0x11 data 0xC3.
REQ-033 Read: START,0xA0,0x20, rSTART,0xA1, reg_rdata returns 0x3C then 0x7E, master ACK then NACK -> SDA shows 0x3C,0x7E; reg_rd at 0x20,0x21; busy=0 after NACK.
REQ-034 Mismatch: START, 0x42 -> sda_oe stays 0 throughout, no reg_wr/reg_rd, busy=0.
REQ-035 Wrap: pointer 0xFF, write 0x11,0x22 -> reg_wr at 0xFF then 0x00.
REQ-036 Abort: STOP after 4 bits of data byte -> no reg_wr, state IDLE; rst mid read bit -> sda_oe=0 same cycle.
